serial_subtractor: RTL and testbench

Multi-cycle digit-serial WIDTH-bit subtractor computing difference = minuend - subtrahend (mod 2^WIDTH) and a borrow flag. It is the inverse-direction counterpart to the team's combinational ripple adder, intended for area-constrained datapaths. It processes DIGIT bits per cycle through a registered borrow chain. Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_subtractor_pkg.sv | 34 +++
 rtl/serial_subtractor_if.sv | 63 ++++++
 rtl/serial_subtractor_full_subtractor.sv | 25 ++
 rtl/serial_subtractor.sv | 203 ++++++++++++++++++++
 tb/tb_serial_subtractor.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
//==============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and constants for the digit-serial subtractor:
//               FSM state encoding, default operand/digit widths and the
//               digit-counter width helper.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package serial_sub_pkg;

    localparam int c_default_width = 32;
    localparam int c_default_digit = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // ceil(log2(width/digit)), never narrower than one bit so that the
    // single-step case (digit == width) still has a legal counter.
    function automatic int cnt_width(input int width, input int digit);
        int steps;
        int w;
        steps = width / digit;
        w     = $clog2(steps);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
//==============================================================================
// Module      : serial_subtractor_if
// Description : Operand/result handshake bundle for serial_subtractor.
//               slave  : subtractor side (accepts operands, offers results)
//               master : producer/consumer side
//               Signals: in_valid/in_ready/minuend/subtrahend (operand
//               channel), out_valid/out_ready/difference/borrow_out (result
//               channel), busy (status). When SERIAL_SUB_OVERFLOW_EN is
//               defined an extra result bit 'overflow' is carried.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = serial_sub_pkg::c_default_width
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] difference;
    logic             borrow_out;
    logic             busy;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    modport slave (
        input  in_valid,
        input  minuend,
        input  subtrahend,
        input  out_ready,
        output in_ready,
        output out_valid,
        output difference,
        output borrow_out,
`ifdef SERIAL_SUB_OVERFLOW_EN
        output overflow,
`endif
        output busy
    );

    modport master (
        output in_valid,
        output minuend,
        output subtrahend,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  difference,
        input  borrow_out,
`ifdef SERIAL_SUB_OVERFLOW_EN
        input  overflow,
`endif
        input  busy
    );

endinterface

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
//==============================================================================
// Module      : full_subtractor
// Description : One-bit full subtractor cell, d = a - b - bin.
//               a, b, bin : minuend bit, subtrahend bit, borrow in
//               d, bout   : difference bit, borrow out
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when a == b and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
//==============================================================================
// Module      : serial_subtractor
// Description : Digit-serial WIDTH-bit subtractor, difference = A - B
//               (mod 2^WIDTH), borrow_out = (A < B) unsigned. DIGIT bits are
//               processed per clock through a registered borrow; a result is
//               offered WIDTH/DIGIT edges after the operands are accepted.
//               clk    : rising-edge clock
//               rst_n  : asynchronous active-low reset
//               sub_if : serial_subtractor_if.slave (operand and result
//                        valid/ready channels, busy status)
//               Optional: define SERIAL_SUB_OVERFLOW_EN to add the registered
//               signed-overflow result bit sub_if.overflow.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int DIGIT = c_default_digit
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave sub_if
);

    localparam int                c_steps    = WIDTH / DIGIT;
    localparam int                CNT_W      = cnt_width(WIDTH, DIGIT);
    localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(c_steps - 1);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);

    generate
        if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_digit
            $error("serial_subtractor: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
        end
    endgenerate

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    state_t           r_state;
    state_t           w_state_next;

    // r_a doubles as the result register: as A drains out of the low end,
    // each finished difference digit is shifted in at the top, so after the
    // last step r_a holds the complete difference.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_difference;
    logic             r_borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             r_overflow;
    logic             w_overflow;
`endif

    logic [DIGIT-1:0] w_digit;
    logic             w_chain [DIGIT+1];
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_b_next;
    logic             w_last;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    //--------------------------------------------------------------------------
    // Digit subtract: DIGIT chained one-bit cells on the low digit
    //--------------------------------------------------------------------------
    assign w_chain[0] = r_borrow;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fs
            full_subtractor u_fs (
                .a    (r_a[i]),
                .b    (r_b[i]),
                .bin  (w_chain[i]),
                .d    (w_digit[i]),
                .bout (w_chain[i+1])
            );
        end
    endgenerate

    generate
        if (DIGIT == WIDTH) begin : g_single_step
            assign w_a_next = w_digit;
            assign w_b_next = '0;
        end else begin : g_multi_step
            assign w_a_next = {w_digit, r_a[WIDTH-1:DIGIT]};
            assign w_b_next = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign w_last = (r_cnt == c_last_cnt);

`ifdef SERIAL_SUB_OVERFLOW_EN
    // On the final step the low digit of r_a/r_b is the top digit of the
    // original operands, so their MSBs are still available here.
    assign w_overflow = (r_a[DIGIT-1] ^ r_b[DIGIT-1]) &
                        (w_digit[DIGIT-1] ^ r_a[DIGIT-1]);
`endif

    //--------------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (sub_if.in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (sub_if.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_difference <= '0;
            r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            r_overflow   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (sub_if.in_valid) begin
                        r_a      <= sub_if.minuend;
                        r_b      <= sub_if.subtrahend;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_a      <= w_a_next;
                    r_b      <= w_b_next;
                    r_borrow <= w_chain[DIGIT];
                    r_cnt    <= r_cnt + c_cnt_one;
                    if (w_last) begin
                        r_difference <= w_a_next;
                        r_borrow_out <= w_chain[DIGIT];
`ifdef SERIAL_SUB_OVERFLOW_EN
                        r_overflow   <= w_overflow;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign sub_if.in_ready   = w_in_ready;
    assign sub_if.out_valid  = w_out_valid;
    assign sub_if.busy       = w_busy;
    assign sub_if.difference = r_difference;
    assign sub_if.borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign sub_if.overflow   = r_overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//==============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor. Directed sequence
//               on a WIDTH=32/DIGIT=4 instance, then randomized operands and
//               handshakes on DIGIT=1/4/32 instances checked against a plain
//               arithmetic reference model. Honors SERIAL_SUB_OVERFLOW_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_subtractor;

    localparam int c_n_ops = 150;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   n_done;
    bit   start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {signed_overflow, unsigned_borrow, difference}
    function automatic logic [33:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        longint     t;
        longint     sd;
        logic [63:0] tv;
        logic       bw;
        logic       ov;
        t   = longint'({32'd0, a}) - longint'({32'd0, b});
        tv  = t;
        bw  = (a < b);
        sd  = longint'($signed(a)) - longint'($signed(b));
        ov  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
        return {ov, bw, tv[31:0]};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    //--------------------------------------------------------------------------
    // Directed instance
    //--------------------------------------------------------------------------
    serial_subtractor_if #(.WIDTH(32)) dif ();

    serial_subtractor #(.WIDTH(32), .DIGIT(4)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sub_if (dif)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        dif.in_valid   = 1'b1;
        dif.minuend    = a;
        dif.subtrahend = b;
        step();
        dif.in_valid = 1'b0;
        lat = 0;
        while ((dif.out_valid !== 1'b1) && (lat < 100)) begin
            step();
            lat++;
        end
    endtask

    //--------------------------------------------------------------------------
    // Randomized instances, DIGIT = 1, 4, 32
    //--------------------------------------------------------------------------
    generate
        for (genvar k = 0; k < 3; k++) begin : g_rand
            localparam int D = (k == 0) ? 1 : ((k == 1) ? 4 : 32);

            serial_subtractor_if #(.WIDTH(32)) rif ();

            serial_subtractor #(.WIDTH(32), .DIGIT(D)) u_dut (
                .clk    (clk),
                .rst_n  (rst_n),
                .sub_if (rif)
            );

            logic [33:0] q[$];
            logic [33:0] e;
            logic [31:0] ra;
            logic [31:0] rb;
            int          acc;
            int          cmp;
            int          cyc;

            initial begin
                rif.in_valid   = 1'b0;
                rif.out_ready  = 1'b0;
                rif.minuend    = '0;
                rif.subtrahend = '0;
                acc = 0;
                cmp = 0;
                cyc = 0;
                wait (start);
                while ((cmp < c_n_ops) && (cyc < c_n_ops * 80)) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                    if (acc < c_n_ops) begin
                        ra = pick();
                        rb = ($urandom_range(0, 7) == 0) ? ra : pick();
                        rif.in_valid   = ($urandom_range(0, 2) != 0);
                        rif.minuend    = ra;
                        rif.subtrahend = rb;
                    end else begin
                        rif.in_valid = 1'b0;
                    end
                    rif.out_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (rif.in_valid && rif.in_ready) begin
                        q.push_back(ref_sub(rif.minuend, rif.subtrahend));
                        acc++;
                    end
                    if (rif.out_valid && rif.out_ready) begin
                        if (q.size() == 0) begin
                            chk($sformatf("d%0d_unexpected_result", D), 32'(rif.out_valid), 32'd0);
                        end else begin
                            e = q.pop_front();
                            chk($sformatf("d%0d_diff", D), rif.difference, e[31:0]);
                            chk($sformatf("d%0d_borrow", D), 32'(rif.borrow_out), 32'(e[32]));
`ifdef SERIAL_SUB_OVERFLOW_EN
                            chk($sformatf("d%0d_ovf", D), 32'(rif.overflow), 32'(e[33]));
`endif
                            cmp++;
                        end
                    end
                end
                rif.in_valid  = 1'b0;
                rif.out_ready = 1'b0;
                chk($sformatf("d%0d_completed", D), 32'(cmp), 32'(c_n_ops));
                chk($sformatf("d%0d_pending", D), 32'(q.size()), 32'd0);
                n_done++;
            end
        end
    endgenerate

    //--------------------------------------------------------------------------
    // Directed sequence
    //--------------------------------------------------------------------------
    int lat;
    int seen;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        n_done = 0;
        start  = 1'b0;
        rst_n  = 1'b0;
        dif.in_valid   = 1'b0;
        dif.out_ready  = 1'b0;
        dif.minuend    = '0;
        dif.subtrahend = '0;

        repeat (3) step();
        chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_diff", dif.difference, 32'd0);
        chk("rst_borrow", 32'(dif.borrow_out), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(dif.in_ready), 32'd1);
        chk("idle_busy", 32'(dif.busy), 32'd0);

        // 10 - 3
        run_op(32'h0000_000A, 32'h0000_0003, lat);
        chk("op1_latency", 32'(lat), 32'd8);
        chk("op1_diff", dif.difference, 32'h0000_0007);
        chk("op1_borrow", 32'(dif.borrow_out), 32'd0);
        chk("op1_in_ready", 32'(dif.in_ready), 32'd0);
        chk("op1_busy", 32'(dif.busy), 32'd1);
        dif.out_ready = 1'b1;
        step();
        dif.out_ready = 1'b0;
        chk("op1_after_valid", 32'(dif.out_valid), 32'd0);
        chk("op1_after_in_ready", 32'(dif.in_ready), 32'd1);
        chk("op1_diff_held", dif.difference, 32'h0000_0007);

        // 0 - 1 wraps
        run_op(32'h0000_0000, 32'h0000_0001, lat);
        chk("wrap_latency", 32'(lat), 32'd8);
        chk("wrap_diff", dif.difference, 32'hFFFF_FFFF);
        chk("wrap_borrow", 32'(dif.borrow_out), 32'd1);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("wrap_ovf", 32'(dif.overflow), 32'd0);
`endif
        dif.out_ready = 1'b1;
        step();
        dif.out_ready = 1'b0;

        // most-negative minus one: signed overflow, no unsigned borrow
        run_op(32'h8000_0000, 32'h0000_0001, lat);
        chk("ovf_diff", dif.difference, 32'h7FFF_FFFF);
        chk("ovf_borrow", 32'(dif.borrow_out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk("ovf_flag", 32'(dif.overflow), 32'd1);
`endif
        dif.out_ready = 1'b1;
        step();
        dif.out_ready = 1'b0;

        // Backpressure: hold result for 20 cycles, in_valid pulses ignored
        run_op(32'h0000_0005, 32'h0000_000C, lat);
        for (int i = 0; i < 20; i++) begin
            dif.in_valid   = i[0];
            dif.minuend    = $urandom();
            dif.subtrahend = $urandom();
            step();
            chk("bp_out_valid", 32'(dif.out_valid), 32'd1);
            chk("bp_in_ready", 32'(dif.in_ready), 32'd0);
            chk("bp_diff", dif.difference, 32'hFFFF_FFF9);
            chk("bp_borrow", 32'(dif.borrow_out), 32'd1);
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        step();
        dif.out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(dif.in_ready), 32'd1);
        chk("bp_release_valid", 32'(dif.out_valid), 32'd0);
        step();
        chk("bp_still_idle", 32'(dif.busy), 32'd0);

        // Reset during the 4th RUN cycle
        dif.in_valid   = 1'b1;
        dif.minuend    = 32'h0000_FFFF;
        dif.subtrahend = 32'h0000_0001;
        step();
        dif.in_valid = 1'b0;
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(dif.busy), 32'd0);
        chk("midrst_out_valid", 32'(dif.out_valid), 32'd0);
        chk("midrst_diff", dif.difference, 32'd0);
        chk("midrst_borrow", 32'(dif.borrow_out), 32'd1 - 32'd1);
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (dif.out_valid === 1'b1) seen++;
        end
        chk("midrst_no_result", 32'(seen), 32'd0);

        run_op(32'h1234_5678, 32'h1234_5678, lat);
        chk("eq_latency", 32'(lat), 32'd8);
        chk("eq_diff", dif.difference, 32'd0);
        chk("eq_borrow", 32'(dif.borrow_out), 32'd0);
        dif.out_ready = 1'b1;
        step();
        dif.out_ready = 1'b0;

        // Randomized phase on the three DIGIT configurations
        start = 1'b1;
        for (int i = 0; (i < 60000) && (n_done < 3); i++) step();
        chk("rand_all_done", 32'(n_done), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
